dump_gate_sequencer: RTL

- Downstream consumer of the dump/sustain timer's `start` pulse.
- On each accepted `start`, emits a burst of dump-gate pulses to the NMR front-end switch drivers: optional pre-delay, then N gate pulses separated by gaps.
- All durations are counted in 100 us ticks derived from `clk_10k`; all logic is clocked on `clk_sys`.
- Reports `busy`, `done` and a restart-collision flag back to the DSP-side state logic.

---
 rtl/dump_gate_sequencer_pkg.sv | 15 +
 rtl/dump_gate_sequencer_if.sv | 30 +++
 rtl/dump_gate_sequencer_tick_sync.sv | 27 ++
 rtl/dump_gate_sequencer.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/dump_gate_sequencer_pkg.sv
// Shared types and default widths for the dump-gate sequencer and its timer-side helpers.
package dump_gate_pkg;

    localparam int CNT_W = 8;
    localparam int REP_W = 4;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        PRE  = 3'd1,
        GATE = 3'd2,
        GAP  = 3'd3,
        DONE = 3'd4
    } state_t;

endpackage

// File: rtl/dump_gate_sequencer_if.sv
// Control/status bundle between the DSP-side state logic (master) and the dump-gate sequencer (slave).
interface dump_gate_sequencer_if
    import dump_gate_pkg::*;
#(
    parameter int CNT_W = dump_gate_pkg::CNT_W,
    parameter int REP_W = dump_gate_pkg::REP_W
);

    logic             start;
    logic             abort;
    logic [CNT_W-1:0] pre_delay;
    logic [CNT_W-1:0] gate_width;
    logic [CNT_W-1:0] gap_width;
    logic [REP_W-1:0] rep_count;
    logic             dump_gate;
    logic             busy;
    logic             done;
    logic             err_restart;

    modport master (
        output start, abort, pre_delay, gate_width, gap_width, rep_count,
        input  dump_gate, busy, done, err_restart
    );

    modport slave (
        input  start, abort, pre_delay, gate_width, gap_width, rep_count,
        output dump_gate, busy, done, err_restart
    );

endinterface

// File: rtl/dump_gate_sequencer_tick_sync.sv
// Brings the asynchronous 10 kHz reference into clk_sys and turns each rising edge into a one-cycle tick.
module tick_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_sys,
    input  logic rst_n,
    input  logic i_clk_10k,
    output logic o_tick
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_syncD;

    // The reference is sampled as data only; the extra flop after the chain gives the edge detector its history.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            r_sync  <= '0;
            r_syncD <= 1'b0;
        end else begin
            r_sync  <= {r_sync[SYNC_STAGES-2:0], i_clk_10k};
            r_syncD <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_tick = r_sync[SYNC_STAGES-1] & ~r_syncD;

endmodule

// File: rtl/dump_gate_sequencer.sv
// Dump-gate burst sequencer: on an accepted start, runs an optional pre-delay and then rep_count gate
// pulses separated by gaps, all timed in clk_10k ticks, and reports busy/done/restart-collision.
module dump_gate_sequencer
    import dump_gate_pkg::*;
#(
    parameter int CNT_W       = dump_gate_pkg::CNT_W,
    parameter int REP_W       = dump_gate_pkg::REP_W,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk_sys,
    input  logic                  rst_n,
    input  logic                  clk_10k,
    dump_gate_sequencer_if.slave  bus
);

    state_t           r_state;
    state_t           w_nextState;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_nextCnt;
    logic [REP_W-1:0] r_rep;
    logic [REP_W-1:0] w_nextRep;
    logic [CNT_W-1:0] r_gateW;
    logic [CNT_W-1:0] r_gapW;
    logic [CNT_W-1:0] w_gateIn;
    logic [CNT_W-1:0] w_gapIn;
    logic             w_accept;
    logic             w_tick;
    logic             r_dumpGate;
    logic             r_busy;
    logic             r_done;
    logic             r_errRestart;

    tick_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_tickSync (
        .clk_sys   (clk_sys),
        .rst_n     (rst_n),
        .i_clk_10k (clk_10k),
        .o_tick    (w_tick)
    );

    // Zero widths are stored as one tick so the down-counter is always reloaded with a non-zero value.
    assign w_gateIn = (bus.gate_width == '0) ? CNT_W'(1) : bus.gate_width;
    assign w_gapIn  = (bus.gap_width  == '0) ? CNT_W'(1) : bus.gap_width;

    always_comb begin
        w_nextState = r_state;
        w_nextCnt   = r_cnt;
        w_nextRep   = r_rep;
        w_accept    = 1'b0;
        if (bus.abort) begin
            w_nextState = IDLE;
            w_nextCnt   = '0;
            w_nextRep   = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        w_accept  = 1'b1;
                        w_nextRep = bus.rep_count;
                        if (bus.rep_count == '0) begin
                            w_nextState = DONE;
                        end else if (bus.pre_delay == '0) begin
                            w_nextState = GATE;
                            w_nextCnt   = w_gateIn;
                        end else begin
                            w_nextState = PRE;
                            w_nextCnt   = bus.pre_delay;
                        end
                    end
                end
                PRE: begin
                    if (w_tick) begin
                        if (r_cnt == CNT_W'(1)) begin
                            w_nextState = GATE;
                            w_nextCnt   = r_gateW;
                        end else begin
                            w_nextCnt = r_cnt - CNT_W'(1);
                        end
                    end
                end
                GATE: begin
                    if (w_tick) begin
                        if (r_cnt == CNT_W'(1)) begin
                            w_nextRep = r_rep - REP_W'(1);
                            if (r_rep == REP_W'(1)) begin
                                w_nextState = DONE;
                                w_nextCnt   = '0;
                            end else begin
                                w_nextState = GAP;
                                w_nextCnt   = r_gapW;
                            end
                        end else begin
                            w_nextCnt = r_cnt - CNT_W'(1);
                        end
                    end
                end
                GAP: begin
                    if (w_tick) begin
                        if (r_cnt == CNT_W'(1)) begin
                            w_nextState = GATE;
                            w_nextCnt   = r_gateW;
                        end else begin
                            w_nextCnt = r_cnt - CNT_W'(1);
                        end
                    end
                end
                DONE: begin
                    w_nextState = IDLE;
                end
                default: begin
                    w_nextState = IDLE;
                    w_nextCnt   = '0;
                    w_nextRep   = '0;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state so they line up exactly with state occupancy.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_rep        <= '0;
            r_gateW      <= '0;
            r_gapW       <= '0;
            r_dumpGate   <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_errRestart <= 1'b0;
        end else begin
            r_state <= w_nextState;
            r_cnt   <= w_nextCnt;
            r_rep   <= w_nextRep;
            if (w_accept) begin
                r_gateW <= w_gateIn;
                r_gapW  <= w_gapIn;
            end
            r_dumpGate   <= (w_nextState == GATE);
            r_busy       <= (w_nextState != IDLE);
            r_done       <= (w_nextState == DONE);
            r_errRestart <= bus.start & ~bus.abort & (r_state != IDLE);
        end
    end

    assign bus.dump_gate   = r_dumpGate;
    assign bus.busy        = r_busy;
    assign bus.done        = r_done;
    assign bus.err_restart = r_errRestart;

endmodule
